// File: rtl/serial_demux_pkg.sv
// Shared constants for the serial feeder and the 1-to-4 demux decoder.
// Holds the state encoding, channel count, destination width and counter sizing.
package serial_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int NUM_CH = 4;
    localparam int DEST_W = 2;

    // Counter only ever holds WIDTH-1 (bit index) or GAP-1 (idle cycles).
    function automatic int cnt_width(input int width, input int gap);
        int need;
        need = (width - 1 > gap - 1) ? width - 1 : gap - 1;
        return ($clog2(need + 1) < 1) ? 1 : $clog2(need + 1);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag.
// Decrement is suppressed at zero, so the count never wraps.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_demux_feeder.sv
// Serializes destination-tagged words MSB-first toward the 1-to-4 demux decoder,
// with a programmable idle gap after each word.
module serial_demux_feeder
    import serial_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              bit_out,
    output logic [DEST_W-1:0] sel_out,
    output logic              bit_valid,
    output logic              last,
    output logic              busy
);

    localparam int               CNT_W    = cnt_width(WIDTH, GAP);
    localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               HAS_GAP  = (GAP > 0);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [DEST_W-1:0]   sel_q, sel_d;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]    cnt_val;

    seq_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        sel_d    = sel_q;
        cnt_load = 1'b0;
        cnt_val  = SHIFT_LD;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d  = in_data;
                    sel_d    = in_dest;
                    cnt_load = 1'b1;
                    cnt_val  = SHIFT_LD;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                if (cnt_zero) begin
                    if (HAS_GAP) begin
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_dec = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs decode from registers only; bit_out is gated so idle reads 0.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign bit_valid = (state_q == ST_SHIFT);
    assign bit_out   = bit_valid & shift_q[WIDTH-1];
    assign last      = bit_valid & cnt_zero;
    assign sel_out   = sel_q;

endmodule

// File: tb/tb_serial_demux_feeder.sv
// Directed bench for serial_demux_feeder: default GAP=1 instance plus a GAP=0 instance.
module tb_serial_demux_feeder;
    import serial_demux_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_data = '0;
    logic [1:0] in_dest = '0;
    logic       bit_out, bit_valid, last, busy;
    logic [1:0] sel_out;

    logic       in_valid1 = 1'b0, in_ready1;
    logic [7:0] in_data1 = '0;
    logic [1:0] in_dest1 = '0;
    logic       bit_out1, bit_valid1, last1, busy1;
    logic [1:0] sel_out1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    serial_demux_feeder #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .bit_out(bit_out), .sel_out(sel_out),
        .bit_valid(bit_valid), .last(last), .busy(busy)
    );

    serial_demux_feeder #(.WIDTH(8), .GAP(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_dest(in_dest1), .bit_out(bit_out1), .sel_out(sel_out1),
        .bit_valid(bit_valid1), .last(last1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs0();
        return {in_ready, busy, bit_valid, bit_out, last, sel_out};
    endfunction

    task automatic run_word(input logic [7:0] d, input logic [1:0] s,
                            input bit scramble, input bit hold, output int acc);
        int n;
        logic [3:0] dexp, dgot;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = s;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        tick();
        acc = cyc;
        if (!hold) in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                in_dest  = 2'($urandom);
            end
            chk("bit", 32'(bit_out), 32'(d[7-i]));
            chk("sel", 32'(sel_out), 32'(s));
            chk("valid", 32'(bit_valid), 32'd1);
            chk("last", 32'(last), 32'(i == 7));
            dexp = d[7-i] ? (4'b0001 << s) : 4'b0000;
            dgot = bit_out ? (4'b0001 << sel_out) : 4'b0000;
            chk("dec", 32'(dgot), 32'(dexp));
            tick();
        end
        chk("gap", 32'({in_ready, busy, bit_valid, bit_out, last}), 32'b01000);
        chk("gap_sel", 32'(sel_out), 32'(s));
        if (scramble) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_dest  = 2'($urandom);
        end
        tick();
        chk("ready_back", 32'({in_ready, busy, bit_valid}), 32'b100);
        chk("idle_sel", 32'(sel_out), 32'(s));
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        int a1, a2, acc2, zeros;
        logic pr;
        logic [7:0] w1;

        // Reset with random inputs: outputs must be in_ready only.
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'(outs0()), 32'h40);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_dest  = 2'($urandom);
            tick();
            chk("rst_hold", 32'(outs0()), 32'h40);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst", 32'(outs0()), 32'h40);
        end

        run_word(8'hA5, 2'd2, 1'b0, 1'b0, a1);

        run_word(8'hFF, 2'd0, 1'b0, 1'b1, a1);
        run_word(8'h01, 2'd3, 1'b0, 1'b0, a2);
        chk("b2b_period", 32'(a2 - a1), 32'd10);

        run_word(8'h6B, 2'd1, 1'b1, 1'b0, a1);
        run_word(8'h92, 2'd3, 1'b1, 1'b0, a1);

        // GAP=0 instance: 9-cycle period, one bubble between words.
        w1 = 8'h96;
        in_valid1 = 1'b1;
        in_data1  = w1;
        in_dest1  = 2'd1;
        tick();
        a1 = cyc;
        in_data1 = 8'h5A;
        in_dest1 = 2'd2;
        zeros = 0;
        acc2 = -1;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) chk("g0_bit", 32'(bit_out1), 32'(w1[7-j]));
            if (j == 7) chk("g0_last", 32'(last1), 32'd1);
            if (j == 8) chk("g0_idle", 32'({in_ready1, bit_valid1}), 32'b10);
            if (!bit_valid1) zeros++;
            pr = in_ready1;
            tick();
            if (pr && acc2 < 0) acc2 = cyc;
        end
        chk("g0_period", 32'(acc2 - a1), 32'd9);
        chk("g0_bubbles", 32'(zeros), 32'd1);
        in_valid1 = 1'b0;
        chk("g0_w2_bit1", 32'({bit_valid1, bit_out1, sel_out1}), 32'b1110);
        for (int j = 0; j < 9; j++) tick();
        chk("g0_done", 32'({in_ready1, busy1, bit_valid1}), 32'b100);

        // Mid-word asynchronous reset after the 4th bit of C3.
        w1 = 8'hC3;
        in_valid = 1'b1;
        in_data  = w1;
        in_dest  = 2'd1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_bit", 32'({bit_out, sel_out}), 32'({w1[7-i], 2'd1}));
            if (i < 3) tick();
        end
        #3 rst_n = 1'b0;
        #1 chk("mid_rst", 32'(outs0()), 32'h40);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_resid", 32'({busy, bit_valid, bit_out, last}), 32'd0);
        end
        run_word(8'h3C, 2'd2, 1'b0, 1'b0, a1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
